// File: rtl/riscv_br_pkg.sv
// rtl/riscv_br_pkg.sv - branch op encodings, BHT counter type and helpers
package riscv_br_pkg;

   localparam logic [4:0] BR_NOP  = 5'd0;
   localparam logic [4:0] BR_EQ   = 5'd1;
   localparam logic [4:0] BR_NE   = 5'd2;
   localparam logic [4:0] BR_LT   = 5'd3;
   localparam logic [4:0] BR_GE   = 5'd4;
   localparam logic [4:0] BR_LTU  = 5'd5;
   localparam logic [4:0] BR_GEU  = 5'd6;
   localparam logic [4:0] BR_JAL  = 5'd7;
   localparam logic [4:0] BR_JALR = 5'd8;

   typedef logic [1:0] bht_ctr_t;
   localparam bht_ctr_t BHT_INIT = 2'b01;

   function automatic logic is_cond_br(input logic [4:0] brop);
      return (brop >= BR_EQ) && (brop <= BR_GEU);
   endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - request/result/prediction bundle of the branch resolve unit
interface branch_resolve_unit_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic [XLEN-1:0] in_imm;
   logic [4:0]      in_brop;
   logic            in_pred_taken;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic            out_taken;
   logic [XLEN-1:0] out_target;
   logic [XLEN-1:0] out_redirect_pc;
   logic            out_mispredict;
   logic [XLEN-1:0] pred_pc;
   logic            pred_taken;

   modport master (
      output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_brop, in_pred_taken, flush,
      output out_ready, pred_pc,
      input  in_ready, out_valid, out_taken, out_target, out_redirect_pc, out_mispredict,
      input  pred_taken
   );

   modport slave (
      input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_brop, in_pred_taken, flush,
      input  out_ready, pred_pc,
      output in_ready, out_valid, out_taken, out_target, out_redirect_pc, out_mispredict,
      output pred_taken
   );
endinterface

// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit saturating counter table indexed by PC word address
module branch_history_table
   import riscv_br_pkg::*;
#(
   parameter int BHT_ENTRIES = 16,
   parameter int XLEN        = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] i_rd_pc,
   output logic            o_rd_taken,
   input  logic            i_wr_en,
   input  logic [XLEN-1:0] i_wr_pc,
   input  logic            i_wr_taken
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   bht_ctr_t              r_ctr [BHT_ENTRIES];
   logic [IDX_W-1:0]      w_rd_idx;
   logic [IDX_W-1:0]      w_wr_idx;
   logic [XLEN-IDX_W-1:0] w_unused_pc_bits;

   assign w_rd_idx = i_rd_pc[IDX_W+1:2];
   assign w_wr_idx = i_wr_pc[IDX_W+1:2];
   assign w_unused_pc_bits = {i_rd_pc[XLEN-1:IDX_W+2], i_rd_pc[1:0]}
                           ^ {i_wr_pc[XLEN-1:IDX_W+2], i_wr_pc[1:0]};

   // Read sees the stored value, so a same-cycle update to the same index is not visible yet
   assign o_rd_taken = r_ctr[w_rd_idx][1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            r_ctr[i] <= BHT_INIT;
         end
      end else if (i_wr_en) begin
         if (i_wr_taken && (r_ctr[w_wr_idx] != 2'b11)) begin
            r_ctr[w_wr_idx] <= r_ctr[w_wr_idx] + 2'd1;
         end else if (!i_wr_taken && (r_ctr[w_wr_idx] != 2'b00)) begin
            r_ctr[w_wr_idx] <= r_ctr[w_wr_idx] - 2'd1;
         end
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch/jump resolution with mispredict flag and BHT training
module branch_resolve_unit
   import riscv_br_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   branch_resolve_unit_if.slave bus
);
   logic            w_eq;
   logic            w_lt;
   logic            w_ltu;
   logic            w_taken;
   logic            w_mis;
   logic            w_can_load;
   logic            w_out_fire;
   logic [XLEN-1:0] w_pc4;
   logic [XLEN-1:0] w_br_tgt;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_redirect;

   logic            r_out_valid;
   logic            r_taken;
   logic            r_mis;
   logic            r_cond;
   logic [XLEN-1:0] r_target;
   logic [XLEN-1:0] r_redirect;
   logic [XLEN-1:0] r_pc;

   assign w_eq       = (bus.in_rs1 == bus.in_rs2);
   assign w_lt       = ($signed(bus.in_rs1) < $signed(bus.in_rs2));
   assign w_ltu      = (bus.in_rs1 < bus.in_rs2);
   assign w_pc4      = bus.in_pc + XLEN'(4);
   assign w_br_tgt   = bus.in_pc + bus.in_imm;
   assign w_jalr_sum = bus.in_rs1 + bus.in_imm;

   always_comb begin
      w_taken  = 1'b0;
      w_target = w_pc4;
      w_mis    = 1'b0;
      case (bus.in_brop)
         BR_EQ:   w_taken = w_eq;
         BR_NE:   w_taken = !w_eq;
         BR_LT:   w_taken = w_lt;
         BR_GE:   w_taken = !w_lt;
         BR_LTU:  w_taken = w_ltu;
         BR_GEU:  w_taken = !w_ltu;
         BR_JAL:  w_taken = 1'b1;
         BR_JALR: w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase
      if (is_cond_br(bus.in_brop) || (bus.in_brop == BR_JAL)) begin
         w_target = w_br_tgt;
      end else if (bus.in_brop == BR_JALR) begin
         w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
      end
      // No BTB, so a JALR target can never have been predicted
      if (is_cond_br(bus.in_brop)) begin
         w_mis = w_taken ^ bus.in_pred_taken;
      end else if (bus.in_brop == BR_JAL) begin
         w_mis = !bus.in_pred_taken;
      end else if (bus.in_brop == BR_JALR) begin
         w_mis = 1'b1;
      end
   end

   assign w_redirect   = w_taken ? w_target : w_pc4;
   assign w_can_load   = !r_out_valid || bus.out_ready;
   assign w_out_fire   = r_out_valid && bus.out_ready && !bus.flush;
   assign bus.in_ready = w_can_load || bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_taken     <= 1'b0;
         r_mis       <= 1'b0;
         r_cond      <= 1'b0;
         r_target    <= '0;
         r_redirect  <= '0;
         r_pc        <= '0;
      end else if (bus.flush) begin
         r_out_valid <= 1'b0;
      end else if (w_can_load) begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_taken    <= w_taken;
            r_mis      <= w_mis;
            r_cond     <= is_cond_br(bus.in_brop);
            r_target   <= w_target;
            r_redirect <= w_redirect;
            r_pc       <= bus.in_pc;
         end
      end
   end

   assign bus.out_valid       = r_out_valid;
   assign bus.out_taken       = r_taken;
   assign bus.out_target      = r_target;
   assign bus.out_redirect_pc = r_redirect;
   assign bus.out_mispredict  = r_mis;

   // Trains on delivered conditional results only; flushed results never reach the table
   branch_history_table #(
      .BHT_ENTRIES (BHT_ENTRIES),
      .XLEN        (XLEN)
   ) u_bht (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rd_pc    (bus.pred_pc),
      .o_rd_taken (bus.pred_taken),
      .i_wr_en    (w_out_fire && r_cond),
      .i_wr_pc    (r_pc),
      .i_wr_taken (r_taken)
   );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - vector table, corner sequences and random scoreboard for branch_resolve_unit
module tb_branch_resolve_unit;
   import riscv_br_pkg::*;

   typedef struct {
      logic        taken;
      logic [31:0] target;
      logic [31:0] redirect;
      logic        mis;
   } res_t;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        pred;
      logic        taken;
      logic [31:0] target;
      logic [31:0] redirect;
      logic        mis;
   } vec_t;

   typedef struct {
      res_t        r;
      logic [4:0]  op;
      logic [31:0] pc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   branch_resolve_unit_if #(.XLEN(32)) bus ();

   branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic res_t ref_resolve(input logic [4:0] op, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2,
                                        input logic [31:0] imm, input logic pred);
      res_t   r;
      longint u1, u2, s1, s2, t, seq;
      u1  = longint'({32'b0, rs1});
      u2  = longint'({32'b0, rs2});
      s1  = (u1 >= 64'sh8000_0000) ? u1 - 64'sh1_0000_0000 : u1;
      s2  = (u2 >= 64'sh8000_0000) ? u2 - 64'sh1_0000_0000 : u2;
      seq = (longint'({32'b0, pc}) + 4) % 64'sh1_0000_0000;
      case (op)
         BR_EQ:   r.taken = (u1 == u2);
         BR_NE:   r.taken = (u1 != u2);
         BR_LT:   r.taken = (s1 < s2);
         BR_GE:   r.taken = (s1 >= s2);
         BR_LTU:  r.taken = (u1 < u2);
         BR_GEU:  r.taken = (u1 >= u2);
         BR_JAL, BR_JALR: r.taken = 1'b1;
         default: r.taken = 1'b0;
      endcase
      if (op >= BR_EQ && op <= BR_JAL) begin
         t = (longint'({32'b0, pc}) + longint'({32'b0, imm})) % 64'sh1_0000_0000;
      end else if (op == BR_JALR) begin
         t = (u1 + longint'({32'b0, imm})) % 64'sh1_0000_0000;
         t = t - (t % 2);
      end else begin
         t = seq;
      end
      r.target   = t[31:0];
      r.redirect = r.taken ? t[31:0] : seq[31:0];
      if (op >= BR_EQ && op <= BR_GEU) r.mis = (r.taken != pred);
      else if (op == BR_JAL)           r.mis = !pred;
      else if (op == BR_JALR)          r.mis = 1'b1;
      else                             r.mis = 1'b0;
      return r;
   endfunction

   task automatic drive_req(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [31:0] imm, input logic pred);
      bus.in_valid      = 1'b1;
      bus.in_brop       = op;
      bus.in_pc         = pc;
      bus.in_rs1        = rs1;
      bus.in_rs2        = rs2;
      bus.in_imm        = imm;
      bus.in_pred_taken = pred;
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   vec_t      vecs[11];
   res_t      ra, rb;
   exp_t      e;
   exp_t      q[$];
   int        bht_m[16];
   logic      bht_exp[3];
   logic [4:0]  op;
   logic [31:0] pc, rs1, rs2, imm;
   logic        pred;
   int          pidx, widx;

   initial begin
      vecs[0]  = '{BR_EQ,   32'h100,      32'd5,        32'd5, 32'h20, 1'b0, 1'b1, 32'h120,  32'h120,  1'b1};
      vecs[1]  = '{BR_LT,   32'h200,      32'hFFFFFFFF, 32'd1, 32'h10, 1'b0, 1'b1, 32'h210,  32'h210,  1'b1};
      vecs[2]  = '{BR_LTU,  32'h200,      32'hFFFFFFFF, 32'd1, 32'h10, 1'b0, 1'b0, 32'h210,  32'h204,  1'b0};
      vecs[3]  = '{BR_GE,   32'h200,      32'hFFFFFFFF, 32'd1, 32'h10, 1'b0, 1'b0, 32'h210,  32'h204,  1'b0};
      vecs[4]  = '{BR_GEU,  32'h200,      32'hFFFFFFFF, 32'd1, 32'h10, 1'b0, 1'b1, 32'h210,  32'h210,  1'b1};
      vecs[5]  = '{BR_JALR, 32'h300,      32'h1001,     32'd0, 32'h2,  1'b1, 1'b1, 32'h1002, 32'h1002, 1'b1};
      vecs[6]  = '{BR_JAL,  32'hFFFFFFF0, 32'd0,        32'd0, 32'h20, 1'b1, 1'b1, 32'h10,   32'h10,   1'b0};
      vecs[7]  = '{BR_NOP,  32'h400,      32'd1,        32'd2, 32'h40, 1'b1, 1'b0, 32'h404,  32'h404,  1'b0};
      vecs[8]  = '{5'd12,   32'h500,      32'd1,        32'd2, 32'h40, 1'b1, 1'b0, 32'h504,  32'h504,  1'b0};
      vecs[9]  = '{BR_NE,   32'h600,      32'd3,        32'd3, 32'h8,  1'b1, 1'b0, 32'h608,  32'h604,  1'b1};
      vecs[10] = '{BR_JALR, 32'h0,        32'hFFFFFFFF, 32'd0, 32'h4,  1'b0, 1'b1, 32'h2,    32'h2,    1'b1};

      bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1; bus.pred_pc = 32'h0;
      bus.in_brop = BR_NOP; bus.in_pc = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
      bus.in_pred_taken = 1'b0;

      // reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_taken", bus.out_taken, 0);
      chk("rst_out_target", bus.out_target, 0);
      chk("rst_out_redirect", bus.out_redirect_pc, 0);
      chk("rst_out_mispredict", bus.out_mispredict, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_pred_taken", bus.pred_taken, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // vector table, back to back
      for (int i = 0; i < 11; i++) begin
         drive_req(vecs[i].op, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pred);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
         chk($sformatf("vec%0d_taken", i), bus.out_taken, vecs[i].taken);
         chk($sformatf("vec%0d_target", i), bus.out_target, vecs[i].target);
         chk($sformatf("vec%0d_redirect", i), bus.out_redirect_pc, vecs[i].redirect);
         chk($sformatf("vec%0d_mispredict", i), bus.out_mispredict, vecs[i].mis);
      end
      @(posedge clk); #1;
      chk("vec_drain_valid", bus.out_valid, 0);

      // backpressure: result held stable with a second request waiting
      ra = ref_resolve(BR_LT, 32'h700, 32'hFFFFFFFF, 32'd1, 32'h40, 1'b0);
      rb = ref_resolve(BR_JAL, 32'h800, 32'd0, 32'd0, 32'h100, 1'b0);
      bus.out_ready = 1'b0;
      drive_req(BR_LT, 32'h700, 32'hFFFFFFFF, 32'd1, 32'h40, 1'b0);
      @(posedge clk); #1;
      drive_req(BR_JAL, 32'h800, 32'd0, 32'd0, 32'h100, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk("stall_in_ready", bus.in_ready, 0);
         chk("stall_out_valid", bus.out_valid, 1);
         chk("stall_target", bus.out_target, ra.target);
         chk("stall_redirect", bus.out_redirect_pc, ra.redirect);
         chk("stall_mispredict", bus.out_mispredict, ra.mis);
         if (k < 3) begin
            @(posedge clk); #1;
         end
      end
      bus.out_ready = 1'b1;
      #1 chk("release_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("release_b_valid", bus.out_valid, 1);
      chk("release_b_target", bus.out_target, rb.target);
      chk("release_b_mispredict", bus.out_mispredict, rb.mis);
      @(posedge clk); #1;
      chk("release_drain_valid", bus.out_valid, 0);

      // BHT training, saturation, same-cycle lookup and aliasing
      do_reset();
      bus.pred_pc = 32'h40;
      #1 chk("bht_init", bus.pred_taken, 0);
      bht_exp[0] = 1'b0; bht_exp[1] = 1'b1; bht_exp[2] = 1'b1;
      drive_req(BR_NE, 32'h40, 32'd1, 32'd2, 32'h10, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (k == 2) bus.in_valid = 1'b0;
         chk($sformatf("bht_pre_update%0d", k), bus.pred_taken, bht_exp[k]);
      end
      @(posedge clk); #1;
      chk("bht_after3", bus.pred_taken, 1);
      bus.pred_pc = 32'h80;
      #1 chk("bht_alias_read", bus.pred_taken, 1);
      drive_req(BR_NE, 32'h80, 32'd7, 32'd7, 32'h10, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("bht_sat_dec1", bus.pred_taken, 1);
      @(posedge clk); #1;
      chk("bht_sat_dec2", bus.pred_taken, 0);
      bus.pred_pc = 32'h40;
      #1 chk("bht_alias_shared", bus.pred_taken, 0);

      // flush with a delivered result and a new request in the same cycle
      bus.pred_pc = 32'h48;
      drive_req(BR_EQ, 32'h48, 32'd9, 32'd9, 32'h10, 1'b0);
      @(posedge clk); #1;
      chk("flush_pre_valid", bus.out_valid, 1);
      drive_req(BR_EQ, 32'h48, 32'd4, 32'd4, 32'h20, 1'b0);
      bus.flush = 1'b1;
      #1 chk("flush_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      chk("flush_out_valid", bus.out_valid, 0);
      chk("flush_no_bht", bus.pred_taken, 0);
      @(posedge clk); #1;
      chk("flush_dropped", bus.out_valid, 0);
      chk("flush_no_bht2", bus.pred_taken, 0);
      bus.out_ready = 1'b0;
      drive_req(BR_NOP, 32'h900, 32'd0, 32'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.flush = 1'b1;
      #1 chk("flush_forces_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.out_ready = 1'b1;
      chk("flush_stalled_valid", bus.out_valid, 0);

      // reset while a result is pending
      bus.pred_pc = 32'h44;
      drive_req(BR_EQ, 32'h44, 32'd6, 32'd6, 32'h40, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b0; bus.in_valid = 1'b0;
      #1 chk("mrst_pre_bht", bus.pred_taken, 1);
      chk("mrst_pre_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", bus.out_valid, 0);
      chk("mrst_out_taken", bus.out_taken, 0);
      chk("mrst_out_target", bus.out_target, 0);
      chk("mrst_out_redirect", bus.out_redirect_pc, 0);
      for (int i = 0; i < 16; i++) begin
         bus.pred_pc = 32'(i * 4);
         #1 chk($sformatf("mrst_bht%0d", i), bus.pred_taken, 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; bus.out_ready = 1'b1;
      #1 chk("mrst_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      drive_req(BR_NE, 32'h4C, 32'd1, 32'd0, 32'h8, 1'b0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      bus.pred_pc = 32'h4C;
      #1 chk("mrst_init_weak", bus.pred_taken, 1);

      // random traffic against the reference model
      do_reset();
      for (int i = 0; i < 16; i++) bht_m[i] = 1;
      for (int c = 0; c < 600; c++) begin
         op   = 5'($urandom_range(0, 10));
         pc   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63) * 4);
         rs1  = $urandom;
         rs2  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
         imm  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128;
         pred = 1'($urandom_range(0, 1));
         drive_req(op, pc, rs1, rs2, imm, pred);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 19) == 0);
         bus.pred_pc   = $urandom;
         #3;
         chk("rnd_out_valid", bus.out_valid, 32'(q.size() > 0));
         chk("rnd_in_ready", bus.in_ready, 32'((q.size() == 0) || bus.out_ready || bus.flush));
         if (q.size() > 0) begin
            chk("rnd_taken", bus.out_taken, q[0].r.taken);
            chk("rnd_target", bus.out_target, q[0].r.target);
            chk("rnd_redirect", bus.out_redirect_pc, q[0].r.redirect);
            chk("rnd_mispredict", bus.out_mispredict, q[0].r.mis);
         end
         pidx = int'((bus.pred_pc / 4) % 16);
         chk("rnd_pred_taken", bus.pred_taken, 32'(bht_m[pidx] >= 2));
         if (bus.flush) begin
            q.delete();
         end else begin
            if (q.size() > 0 && bus.out_ready) begin
               e = q.pop_front();
               if (e.op >= BR_EQ && e.op <= BR_GEU) begin
                  widx = int'((e.pc / 4) % 16);
                  if (e.r.taken) bht_m[widx] = (bht_m[widx] + 1 > 3) ? 3 : bht_m[widx] + 1;
                  else           bht_m[widx] = (bht_m[widx] - 1 < 0) ? 0 : bht_m[widx] - 1;
               end
            end
            if (bus.in_valid && q.size() == 0) begin
               e.r  = ref_resolve(op, pc, rs1, rs2, imm, pred);
               e.op = op;
               e.pc = pc;
               q.push_back(e);
            end
         end
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
